// File: rtl/mdr_result_display_pkg.sv
// -----------------------------------------------------------------------------
// mdr_result_display_pkg
// Shared types and constants for the MDR result display stage: FSM state
// encoding, BCD digit and segment-bus types, active-low segment patterns and
// the double-dabble nibble adjust helper.
// -----------------------------------------------------------------------------
package mdr_result_display_pkg;

  localparam int DW_MDR        = 10;
  localparam int SEGMENT_WIDTH = 7;
  localparam int W_BCD         = 12;
  localparam int N_SHIFTS      = DW_MDR;
  localparam int W_CNT         = 4;

  typedef logic [3:0]               bcd_digit;
  typedef logic [SEGMENT_WIDTH-1:0] segments_conf;

  // Active-low patterns, bit order gfedcba.
  localparam segments_conf SEG_BLANK = 7'h7F;
  localparam segments_conf SEG_MINUS = 7'h3F;
  localparam segments_conf SEG_E     = 7'h06;
  localparam segments_conf SEG_R     = 7'h2F;

  typedef enum logic [1:0] {
    DISP_IDLE    = 2'd0,
    DISP_CONVERT = 2'd1,
    DISP_LATCH   = 2'd2
  } disp_state_e;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift so
  // that the shift carries correctly into the next decimal digit.
  function automatic logic [W_BCD-1:0] dd_adjust(input logic [W_BCD-1:0] bcd);
    logic [W_BCD-1:0] res;
    res = bcd;
    for (int i = 0; i < W_BCD / 4; i++) begin
      if (res[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = res[i*4 +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mdr_seg7_encoder.sv
// -----------------------------------------------------------------------------
// mdr_seg7_encoder
// Combinational BCD digit to active-low seven-segment pattern (gfedcba).
// Nibbles above 9 are not decimal digits and are shown blank.
//   i_digit : BCD digit
//   o_seg   : active-low segment pattern
// -----------------------------------------------------------------------------
module mdr_seg7_encoder
  import mdr_result_display_pkg::*;
(
  input  bcd_digit     i_digit,
  output segments_conf o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0:    o_seg = 7'h40;
      4'd1:    o_seg = 7'h79;
      4'd2:    o_seg = 7'h24;
      4'd3:    o_seg = 7'h30;
      4'd4:    o_seg = 7'h19;
      4'd5:    o_seg = 7'h12;
      4'd6:    o_seg = 7'h02;
      4'd7:    o_seg = 7'h78;
      4'd8:    o_seg = 7'h00;
      4'd9:    o_seg = 7'h10;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/mdr_result_display.sv
// -----------------------------------------------------------------------------
// mdr_result_display
// Converts a signed MDR result (or an error flag) into four registered,
// active-low seven-segment digits: sign, hundreds, tens, units. The magnitude
// is converted to BCD by a sequential double-dabble engine (one shift/cycle).
//
// Handshake: i_start is a one-cycle request sampled only while idle (o_busy=0);
// i_result/i_error are captured with it. Requests while busy are dropped. When
// the new digits appear on the segment outputs, o_done pulses for exactly one
// cycle; the next request is accepted in that same cycle.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_start               : conversion request
//   i_result [DW-1:0]     : two's-complement result
//   i_error               : show "Err" instead of a number
//   o_busy                : high whenever not idle
//   o_done                : one-cycle pulse with new segment values
//   o_seg_sign/hund/tens/unit [SEG_W-1:0] : active-low digits
// -----------------------------------------------------------------------------
module mdr_result_display
  import mdr_result_display_pkg::*;
#(
  parameter int DW    = DW_MDR,
  parameter int SEG_W = SEGMENT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [DW-1:0]    i_result,
  input  logic             i_error,
  output logic             o_busy,
  output logic             o_done,
  output logic [SEG_W-1:0] o_seg_sign,
  output logic [SEG_W-1:0] o_seg_hund,
  output logic [SEG_W-1:0] o_seg_tens,
  output logic [SEG_W-1:0] o_seg_unit
);

  disp_state_e       r_state;
  disp_state_e       w_next;

  logic              r_sign;
  logic              r_err;
  logic [DW:0]       r_mag;
  logic [W_BCD-1:0]  r_bcd;
  logic [W_CNT-1:0]  r_cnt;
  logic              r_done;
  logic [SEG_W-1:0]  r_seg_sign;
  logic [SEG_W-1:0]  r_seg_hund;
  logic [SEG_W-1:0]  r_seg_tens;
  logic [SEG_W-1:0]  r_seg_unit;

  logic [DW:0]       w_ext;
  logic [DW:0]       w_abs;
  logic [W_BCD-1:0]  w_bcd_adj;
  logic              w_last_shift;
  bcd_digit          w_hund;
  bcd_digit          w_tens;
  bcd_digit          w_unit;
  segments_conf      w_enc_hund;
  segments_conf      w_enc_tens;
  segments_conf      w_enc_unit;

  // One extra bit so that the most negative input (-512) has a representable
  // magnitude.
  assign w_ext        = {i_result[DW-1], i_result};
  assign w_abs        = i_result[DW-1] ? ('0 - w_ext) : w_ext;
  assign w_bcd_adj    = dd_adjust(r_bcd);
  assign w_last_shift = (r_cnt == W_CNT'(N_SHIFTS - 1));

  assign w_hund = r_bcd[11:8];
  assign w_tens = r_bcd[7:4];
  assign w_unit = r_bcd[3:0];

  mdr_seg7_encoder u_enc_hund (.i_digit(w_hund), .o_seg(w_enc_hund));
  mdr_seg7_encoder u_enc_tens (.i_digit(w_tens), .o_seg(w_enc_tens));
  mdr_seg7_encoder u_enc_unit (.i_digit(w_unit), .o_seg(w_enc_unit));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DISP_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DISP_IDLE: begin
        if (i_start) begin
          w_next = i_error ? DISP_LATCH : DISP_CONVERT;
        end
      end
      DISP_CONVERT: begin
        if (w_last_shift) begin
          w_next = DISP_LATCH;
        end
      end
      DISP_LATCH: begin
        w_next = DISP_IDLE;
      end
      default: begin
        w_next = DISP_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: capture, double-dabble shifting, output latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign     <= 1'b0;
      r_err      <= 1'b0;
      r_mag      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_seg_sign <= SEG_BLANK;
      r_seg_hund <= SEG_BLANK;
      r_seg_tens <= SEG_BLANK;
      r_seg_unit <= SEG_BLANK;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        DISP_IDLE: begin
          if (i_start) begin
            r_err <= i_error;
            if (!i_error) begin
              r_sign <= i_result[DW-1];
              r_mag  <= w_abs;
              r_bcd  <= '0;
              r_cnt  <= '0;
            end
          end
        end
        DISP_CONVERT: begin
          // Only bits DW-1..0 of the magnitude are shifted into the BCD
          // accumulator; the top bit is zero for every legal magnitude.
          r_bcd <= W_BCD'({w_bcd_adj, r_mag[DW-1]});
          r_mag <= r_mag << 1;
          r_cnt <= r_cnt + W_CNT'(1);
        end
        DISP_LATCH: begin
          r_done <= 1'b1;
          if (r_err) begin
            r_seg_sign <= SEG_BLANK;
            r_seg_hund <= SEG_E;
            r_seg_tens <= SEG_R;
            r_seg_unit <= SEG_R;
          end else begin
            // Leading-zero suppression; units always shown.
            r_seg_sign <= r_sign ? SEG_MINUS : SEG_BLANK;
            r_seg_hund <= (w_hund == 4'd0) ? SEG_BLANK : w_enc_hund;
            r_seg_tens <= (w_hund == 4'd0 && w_tens == 4'd0) ? SEG_BLANK : w_enc_tens;
            r_seg_unit <= w_enc_unit;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy     = (r_state != DISP_IDLE);
  assign o_done     = r_done;
  assign o_seg_sign = r_seg_sign;
  assign o_seg_hund = r_seg_hund;
  assign o_seg_tens = r_seg_tens;
  assign o_seg_unit = r_seg_unit;

endmodule

// File: tb/tb_mdr_result_display.sv
module tb_mdr_result_display;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic [9:0] i_result;
  logic       i_error;
  logic       o_busy;
  logic       o_done;
  logic [6:0] o_seg_sign;
  logic [6:0] o_seg_hund;
  logic [6:0] o_seg_tens;
  logic [6:0] o_seg_unit;

  int errors = 0;
  int checks = 0;

  logic [27:0] exp_last;
  logic [6:0]  seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  mdr_result_display dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_result   (i_result),
    .i_error    (i_error),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_seg_sign (o_seg_sign),
    .o_seg_hund (o_seg_hund),
    .o_seg_tens (o_seg_tens),
    .o_seg_unit (o_seg_unit)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: decimal digits from plain integer arithmetic.
  function automatic logic [27:0] model(input logic [9:0] res, input bit err);
    int v, mag, h, t, u;
    logic [6:0] s_sign, s_h, s_t, s_u;
    if (err) return {7'h7F, 7'h06, 7'h2F, 7'h2F};
    v   = res[9] ? int'(res) - 1024 : int'(res);
    mag = (v < 0) ? -v : v;
    h   = mag / 100;
    t   = (mag / 10) % 10;
    u   = mag % 10;
    s_sign = (v < 0) ? 7'h3F : 7'h7F;
    s_h    = (h == 0) ? 7'h7F : seg_tab[h];
    s_t    = (h == 0 && t == 0) ? 7'h7F : seg_tab[t];
    s_u    = seg_tab[u];
    return {s_sign, s_h, s_t, s_u};
  endfunction

  task automatic check_segs(input string tag, input logic [27:0] e);
    check({tag, "_sign"}, 32'(o_seg_sign), 32'(e[27:21]));
    check({tag, "_hund"}, 32'(o_seg_hund), 32'(e[20:14]));
    check({tag, "_tens"}, 32'(o_seg_tens), 32'(e[13:7]));
    check({tag, "_unit"}, 32'(o_seg_unit), 32'(e[6:0]));
  endtask

  // driver: starts at posedge+1 with DUT idle, returns at the sample point
  // where o_done is seen (or the cycle budget expires).
  task automatic run(input logic [9:0] res, input bit err, input int poke_at, input string tag);
    int n, busy_n, lat;
    exp_last = model(res, err);
    lat      = err ? 1 : 11;
    i_start  = 1'b1;
    i_result = res;
    i_error  = err;
    @(posedge clk); #1;
    i_start  = 1'b0;
    i_error  = 1'b0;
    i_result = 10'($urandom);
    n = 0;
    busy_n = 0;
    while (o_done !== 1'b1 && n < 40) begin
      if (o_busy === 1'b1) busy_n++;
      if (n == poke_at) begin
        i_start  = 1'b1;
        i_result = 10'd300;
      end else begin
        i_start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    i_start = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(lat));
    check({tag, "_busy_at_done"}, 32'(o_busy), 32'd0);
    check_segs(tag, exp_last);
  endtask

  task automatic done_low(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_fall"}, 32'(o_done), 32'd0);
    check_segs({tag, "_hold"}, exp_last);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (o_done === 1'b1) cnt++;
    end
  endtask

  initial begin
    int extra;
    logic [9:0] r;
    bit e;

    rst_n    = 1'b0;
    i_start  = 1'b0;
    i_result = '0;
    i_error  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check_segs("rst", {7'h7F, 7'h7F, 7'h7F, 7'h7F});
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(10'd0, 1'b0, -1, "zero");
    done_low("zero");

    run(10'd123, 1'b0, -1, "p123");
    done_low("p123");

    run(10'h200, 1'b0, -1, "m512");
    done_low("m512");

    run(10'h3F9, 1'b0, -1, "m7");
    done_low("m7");

    // error result, then 511 accepted in the first idle cycle
    run(10'd0, 1'b1, -1, "err");
    run(10'd511, 1'b0, -1, "p511_b2b");
    done_low("p511");
    repeat (3) @(posedge clk);
    #1;
    check_segs("idle_hold", exp_last);

    // start while busy is dropped
    run(10'd45, 1'b0, 5, "p45_ign");
    count_dones(15, extra);
    check("p45_single_done", 32'(extra), 32'd0);
    check_segs("p45_after", exp_last);

    // asynchronous reset in the middle of a conversion
    i_start  = 1'b1;
    i_result = 10'd77;
    i_error  = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    check_segs("midrst", {7'h7F, 7'h7F, 7'h7F, 7'h7F});
    #2;
    rst_n = 1'b1;
    count_dones(15, extra);
    check("midrst_no_done", 32'(extra), 32'd0);

    run(10'd9, 1'b0, -1, "p9");
    done_low("p9");

    // randomized results and occasional error flags
    for (int k = 0; k < 25; k++) begin
      r = 10'($urandom_range(0, 1023));
      e = ($urandom_range(0, 7) == 0);
      run(r, e, -1, $sformatf("rnd%0d", k));
      done_low($sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
